// File: rtl/sram_req_bridge_if.sv
// sram_req_bridge_if: request/response port and SRAM bank port bundles for the SRAM bridge.
interface sram_req_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  modport master (output req_valid, req_we, req_addr, req_wdata, req_be,
                  input  req_ready, resp_valid, resp_rdata, resp_err);
  modport slave  (input  req_valid, req_we, req_addr, req_wdata, req_be,
                  output req_ready, resp_valid, resp_rdata, resp_err);
endinterface

interface sram_mem_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_ce;
  logic [DATA_W-1:0] mem_rdata;
  modport master (output mem_addr, mem_wdata, mem_we, mem_ce, input mem_rdata);
  modport slave  (input mem_addr, mem_wdata, mem_we, mem_ce, output mem_rdata);
endinterface

// File: rtl/sram_req_bridge.sv
// sram_req_bridge: byte-addressed valid/ready requests to single-port SRAM word accesses, RMW for partial writes.
module sram_req_bridge #(
  parameter int REQ_ADDR_WIDTH = 32,
  parameter int SRAM_BANK_ADDR_WIDTH = 14,
  parameter int SRAM_BANK_DATA_WIDTH = 32,
  parameter logic [REQ_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input logic i_clk,
  input logic i_rst_n,
  sram_req_if.slave req,
  sram_mem_if.master mem
);
  localparam int BE_W = SRAM_BANK_DATA_WIDTH / 8;
  localparam int WW = REQ_ADDR_WIDTH - 2;
  typedef enum logic [1:0] {IDLE, RD_WAIT, RMW, RESP} state_t;
  state_t state;
  logic err_q;
  logic [SRAM_BANK_ADDR_WIDTH-1:0] lat_word;
  logic [SRAM_BANK_DATA_WIDTH-1:0] lat_wdata, merged;
  logic [BE_W-1:0] lat_be;
  logic [WW-1:0] off_w;
  logic hs, dec_err, acc, full, partial;
  // Word offset from the bank base; any bit above the bank range means out-of-range.
  always_comb begin
    off_w = req.req_addr[REQ_ADDR_WIDTH-1:2] - BASE_ADDR[REQ_ADDR_WIDTH-1:2];
    hs = req.req_valid & (state == IDLE);
    dec_err = (|req.req_addr[1:0]) | (|off_w[WW-1:SRAM_BANK_ADDR_WIDTH]);
    full = &req.req_be;
    partial = (|req.req_be) & !full;
    acc = hs & !dec_err & (!req.req_we | (|req.req_be));
    merged = mem.mem_rdata;
    for (int b = 0; b < BE_W; b++)
      merged[8*b +: 8] = lat_be[b] ? lat_wdata[8*b +: 8] : mem.mem_rdata[8*b +: 8];
  end
  assign req.req_ready = state == IDLE;
  assign req.resp_valid = (state == RD_WAIT) | (state == RESP);
  assign req.resp_err = (state == RESP) & err_q;
  assign req.resp_rdata = state == RD_WAIT ? mem.mem_rdata : '0;
  // Gating with i_rst_n keeps the SRAM idle during reset, including an aborted RMW write.
  assign mem.mem_ce = i_rst_n & ((state == RMW) | acc);
  assign mem.mem_we = i_rst_n & ((state == RMW) | (acc & req.req_we & full));
  assign mem.mem_addr = state == RMW ? lat_word : off_w[SRAM_BANK_ADDR_WIDTH-1:0];
  assign mem.mem_wdata = state == RMW ? merged : req.req_wdata;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      err_q <= 1'b0;
      lat_word <= '0;
      lat_wdata <= '0;
      lat_be <= '0;
    end else begin
      case (state)
        IDLE: if (hs) begin
          err_q <= dec_err;
          lat_word <= off_w[SRAM_BANK_ADDR_WIDTH-1:0];
          lat_wdata <= req.req_wdata;
          lat_be <= req.req_be;
          state <= (dec_err || (req.req_we && !partial)) ? RESP : req.req_we ? RMW : RD_WAIT;
        end
        RMW: state <= RESP;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_req_bridge.sv
// tb_sram_req_bridge: directed requests with a response scoreboard and an SRAM bank model.
module tb_sram_req_bridge;
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;
  int n_ce = 0;
  int n_we = 0;
  int c0, w0;
  logic [31:0] marr [0:16383];
  logic [31:0] mem_rd;
  exp_t sb[$];

  sram_req_if #(.ADDR_W(32), .DATA_W(32)) rq ();
  sram_mem_if #(.ADDR_W(14), .DATA_W(32)) mm ();

  sram_req_bridge #(
    .REQ_ADDR_WIDTH(32),
    .SRAM_BANK_ADDR_WIDTH(14),
    .SRAM_BANK_DATA_WIDTH(32),
    .BASE_ADDR(32'h0)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .req(rq),
    .mem(mm)
  );

  assign mm.mem_rdata = mem_rd;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (mm.mem_ce) begin
      n_ce <= n_ce + 1;
      if (mm.mem_we) begin
        marr[mm.mem_addr] <= mm.mem_wdata;
        n_we <= n_we + 1;
      end else mem_rd <= marr[mm.mem_addr];
    end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rst_n && rq.resp_valid) begin
      exp_t e;
      if (sb.size() == 0) chk("unexpected_resp", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        chk("resp_rdata", rq.resp_rdata, e.rdata);
        chk("resp_err", rq.resp_err, e.err);
        chk("resp_cycle", cyc, e.cyc);
      end
    end

  // Called at a negedge; returns at the negedge right after the accepting edge with req_valid still high.
  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input logic [31:0] er, input logic ee,
                      input int lat, input bit track);
    int t = 0;
    rq.req_valid = 1'b1;
    rq.req_we = we;
    rq.req_addr = addr;
    rq.req_wdata = wdata;
    rq.req_be = be;
    while (!rq.req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!rq.req_ready) chk("accept_timeout", 64'd0, 64'd1);
    else begin
      if (track) sb.push_back('{er, ee, cyc + lat});
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int t = 0;
    rq.req_valid = 1'b0;
    while (sb.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16384; i++) marr[i] = 32'h0;
    mem_rd = 32'h0;
    rq.req_valid = 1'b1;
    rq.req_we = 1'b0;
    rq.req_addr = 32'h0;
    rq.req_wdata = 32'h0;
    rq.req_be = 4'h0;
    repeat (2) @(negedge clk);
    chk("rst_resp_valid", rq.resp_valid, 0);
    chk("rst_resp_err", rq.resp_err, 0);
    chk("rst_resp_rdata", rq.resp_rdata, 0);
    chk("rst_mem_ce", mm.mem_ce, 0);
    chk("rst_mem_we", mm.mem_we, 0);
    rq.req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", rq.req_ready, 1);

    c0 = n_ce; w0 = n_we;
    send(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1, 1'b1);
    chk("t1_ce_count", n_ce - c0, 1);
    chk("t1_we_count", n_we - w0, 1);
    send(1'b0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1, 1'b1);
    drain();

    c0 = n_ce; w0 = n_we;
    send(1'b1, 32'h100, 32'h000000AA, 4'b0001, 32'h0, 1'b0, 2, 1'b1);
    drain();
    chk("t2_ce_count", n_ce - c0, 2);
    chk("t2_we_count", n_we - w0, 1);
    chk("t2_word", marr[64], 32'hDEADBEAA);
    send(1'b0, 32'h100, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, 1, 1'b1);
    drain();

    c0 = n_ce;
    send(1'b0, 32'h102, 32'h0, 4'h0, 32'h0, 1'b1, 1, 1'b1);
    send(1'b0, 32'h10000, 32'h0, 4'h0, 32'h0, 1'b1, 1, 1'b1);
    drain();
    chk("t3_no_ce", n_ce - c0, 0);

    send(1'b1, 32'h0, 32'h11111111, 4'hF, 32'h0, 1'b0, 1, 1'b1);
    send(1'b1, 32'h4, 32'h22222222, 4'hF, 32'h0, 1'b0, 1, 1'b1);
    send(1'b1, 32'h8, 32'h33333333, 4'hF, 32'h0, 1'b0, 1, 1'b1);
    drain();
    send(1'b0, 32'h0, 32'h0, 4'h0, 32'h11111111, 1'b0, 1, 1'b1);
    chk("t4_ready_rd_wait", rq.req_ready, 0);
    send(1'b0, 32'h4, 32'h0, 4'h0, 32'h22222222, 1'b0, 1, 1'b1);
    send(1'b0, 32'h8, 32'h0, 4'h0, 32'h33333333, 1'b0, 1, 1'b1);
    drain();

    c0 = n_ce;
    send(1'b1, 32'h200, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, 1, 1'b1);
    drain();
    chk("t5_no_ce", n_ce - c0, 0);
    chk("t5_word", marr[128], 32'h0);

    send(1'b1, 32'h10, 32'h12345678, 4'hF, 32'h0, 1'b0, 1, 1'b1);
    drain();
    send(1'b1, 32'h10, 32'h000000FF, 4'b0001, 32'h0, 1'b0, 2, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_ce_in_rst", mm.mem_ce, 0);
    repeat (2) @(negedge clk);
    rq.req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_ready", rq.req_ready, 1);
    chk("t6_word", marr[4], 32'h12345678);
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
